// File: rtl/vproc_pkg.sv
// Shared types and default sizing for the vector pending-write tracker.
package vproc_pkg;

  localparam int VPROC_NUM_VREGS = 32;
  localparam int VPROC_ID_W      = 3;
  localparam int VPROC_CLR_PORTS = 3;
  localparam int PEND_ENTRIES    = 2**VPROC_ID_W;

  typedef logic [VPROC_ID_W-1:0]      pend_id_t;
  typedef logic [VPROC_NUM_VREGS-1:0] vreg_mask_t;

endpackage

// File: rtl/vproc_pending_wr_entry.sv
// One slice of the pending-write table: valid bit, destination mask and local hit decode.
// VPROC_PEND_PARTIAL_CLR_EN enables per-vreg partial release ports.
module vproc_pending_wr_entry
  import vproc_pkg::*;
#(
  parameter int NUM_VREGS = VPROC_NUM_VREGS,
  parameter int ID_W      = VPROC_ID_W,
  parameter int CLR_PORTS = VPROC_CLR_PORTS,
  parameter int IDX       = 0
) (
  input  logic                          clk_i,
  input  logic                          async_rst_ni,
  input  logic                          flush_i,
  input  logic                          issue_fire_i,
  input  logic [ID_W-1:0]               issue_id_i,
  input  logic [NUM_VREGS-1:0]          issue_mask_i,
`ifdef VPROC_PEND_PARTIAL_CLR_EN
  input  logic [CLR_PORTS-1:0]          clr_valid_i,
  input  logic [CLR_PORTS*ID_W-1:0]     clr_id_i,
  input  logic [CLR_PORTS*NUM_VREGS-1:0] clr_mask_i,
`endif
  input  logic [CLR_PORTS-1:0]          retire_valid_i,
  input  logic [CLR_PORTS*ID_W-1:0]     retire_id_i,
  output logic                          valid_o,
  output logic [NUM_VREGS-1:0]          mask_o,
  output logic                          retire_hit_o
);

  localparam logic [ID_W-1:0] MY_ID = ID_W'(IDX);

  logic issue_hit;
  logic retire_hit;

  assign issue_hit = issue_fire_i && (issue_id_i == MY_ID);

  always_comb begin
    retire_hit = 1'b0;
    for (int p = 0; p < CLR_PORTS; p++)
      if (retire_valid_i[p] && (retire_id_i[p*ID_W +: ID_W] == MY_ID)) retire_hit = 1'b1;
  end

`ifdef VPROC_PEND_PARTIAL_CLR_EN
  logic [NUM_VREGS-1:0] clr_bits;

  // Several units finishing parts of the same instruction combine their releases.
  always_comb begin
    clr_bits = '0;
    for (int p = 0; p < CLR_PORTS; p++)
      if (clr_valid_i[p] && (clr_id_i[p*ID_W +: ID_W] == MY_ID))
        clr_bits = clr_bits | clr_mask_i[p*NUM_VREGS +: NUM_VREGS];
  end
`endif

  // Priority issue > retire > release: a new instruction's mask is never touched by
  // releases aimed at the previous occupant of the slot.
  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      valid_o <= 1'b0;
      mask_o  <= '0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
      mask_o  <= '0;
    end else if (issue_hit) begin
      valid_o <= 1'b1;
      mask_o  <= issue_mask_i;
    end else if (retire_hit) begin
      valid_o <= 1'b0;
      mask_o  <= '0;
    end
`ifdef VPROC_PEND_PARTIAL_CLR_EN
    else if (valid_o) begin
      mask_o <= mask_o & ~clr_bits;
    end
`endif
  end

  assign retire_hit_o = retire_hit;

endmodule

// File: rtl/vproc_pending_wr_tracker.sv
// Multi-entry vector pending-write scoreboard with RAW hazard flag for the dispatcher.
// VPROC_PEND_PARTIAL_CLR_EN enables per-vreg partial release; otherwise masks drop only at retire.
module vproc_pending_wr_tracker
  import vproc_pkg::*;
#(
  parameter int NUM_VREGS = VPROC_NUM_VREGS,
  parameter int ID_W      = VPROC_ID_W,
  parameter int CLR_PORTS = VPROC_CLR_PORTS
) (
  input  logic                           clk_i,
  input  logic                           async_rst_ni,
  input  logic                           flush_i,
  input  logic                           issue_valid_i,
  output logic                           issue_ready_o,
  input  logic [ID_W-1:0]                issue_id_i,
  input  logic [NUM_VREGS-1:0]           issue_mask_i,
  input  logic [CLR_PORTS-1:0]           clr_valid_i,
  input  logic [CLR_PORTS*ID_W-1:0]      clr_id_i,
  input  logic [CLR_PORTS*NUM_VREGS-1:0] clr_mask_i,
  input  logic [CLR_PORTS-1:0]           retire_valid_i,
  input  logic [CLR_PORTS*ID_W-1:0]      retire_id_i,
  input  logic [NUM_VREGS-1:0]           rd_mask_i,
  output logic                           hazard_o,
  output logic [NUM_VREGS-1:0]           pending_wr_o,
  output logic                           busy_o,
  output logic                           err_o
);

  localparam int ENTRIES = 2**ID_W;

  logic [ENTRIES-1:0]                ent_valid;
  logic [ENTRIES-1:0]                ent_ret_hit;
  logic [ENTRIES-1:0][NUM_VREGS-1:0] ent_mask;
  logic                              issue_fire;
  logic [NUM_VREGS-1:0]              pend_or;
  logic                              err_set;
  logic                              err_q;

  // A slot being retired this cycle can be reused immediately.
  assign issue_ready_o = !ent_valid[issue_id_i] || ent_ret_hit[issue_id_i];
  assign issue_fire    = issue_valid_i && issue_ready_o;

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ent
    vproc_pending_wr_entry #(
      .NUM_VREGS (NUM_VREGS),
      .ID_W      (ID_W),
      .CLR_PORTS (CLR_PORTS),
      .IDX       (e)
    ) u_ent (
      .clk_i          (clk_i),
      .async_rst_ni   (async_rst_ni),
      .flush_i        (flush_i),
      .issue_fire_i   (issue_fire),
      .issue_id_i     (issue_id_i),
      .issue_mask_i   (issue_mask_i),
`ifdef VPROC_PEND_PARTIAL_CLR_EN
      .clr_valid_i    (clr_valid_i),
      .clr_id_i       (clr_id_i),
      .clr_mask_i     (clr_mask_i),
`endif
      .retire_valid_i (retire_valid_i),
      .retire_id_i    (retire_id_i),
      .valid_o        (ent_valid[e]),
      .mask_o         (ent_mask[e]),
      .retire_hit_o   (ent_ret_hit[e])
    );
  end

`ifndef VPROC_PEND_PARTIAL_CLR_EN
  logic unused_clr;
  assign unused_clr = ^{clr_valid_i, clr_id_i, clr_mask_i};
`endif

  // Invalid entries always hold a zero mask, so a plain OR is enough.
  always_comb begin
    pend_or = '0;
    for (int e = 0; e < ENTRIES; e++) pend_or = pend_or | ent_mask[e];
  end

  always_comb begin
    err_set = issue_valid_i && !issue_ready_o;
    for (int p = 0; p < CLR_PORTS; p++) begin
      if (retire_valid_i[p] && !ent_valid[retire_id_i[p*ID_W +: ID_W]]) err_set = 1'b1;
`ifdef VPROC_PEND_PARTIAL_CLR_EN
      if (clr_valid_i[p] && !ent_valid[clr_id_i[p*ID_W +: ID_W]]) err_set = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni)  err_q <= 1'b0;
    else if (flush_i)   err_q <= 1'b0;
    else if (err_set)   err_q <= 1'b1;
  end

  assign pending_wr_o = pend_or;
  assign busy_o       = |ent_valid;
  assign err_o        = err_q;
  // Same-cycle releases are not subtracted, so the flag errs on the safe side.
  assign hazard_o     = |(rd_mask_i & (pend_or | (issue_fire ? issue_mask_i : '0)));

endmodule

// File: doc/vproc_pending_wr_tracker.md
Name: vproc_pending_wr_tracker

Overview:
Sequential scoreboard that owns the vector-register pending-write state for all in-flight vector instructions.
- Each instruction is registered at dispatch with its ID and destination mask; the mask comes from the combinational pending-write mask generator.
- Execution units release registers per vreg as results are written, or all at once at retire.
- Produces the aggregate pending-write vector and a same-cycle read-after-write hazard flag for the dispatcher.
- Generalises single-instruction mask generation to a parametrised multi-entry, multi-port tracker.

Parameters:
- NUM_VREGS, 32, number of architectural vector registers (mask width).
- ID_W, 3, instruction ID width; table depth is 2**ID_W entries.
- CLR_PORTS, 3, number of independent release/retire ports (one per unit).

Ports:
- clk_i  in  1  clock.
- async_rst_ni  in  1  reset, asynchronous, active-low.
- flush_i  in  1  synchronous clear of all entries.
- issue_valid_i  in  1  dispatch request.
- issue_ready_o  out  1  target entry free (or retiring this cycle).
- issue_id_i  in  ID_W  entry index.
- issue_mask_i  in  NUM_VREGS  destination vregs; all-zero is legal (stores, scalar dest).
- clr_valid_i  in  CLR_PORTS  partial-release strobe, one per port.
- clr_id_i  in  CLR_PORTS*ID_W  entry index per port.
- clr_mask_i  in  CLR_PORTS*NUM_VREGS  vregs completed, per port.
- retire_valid_i  in  CLR_PORTS  retire strobe, one per port.
- retire_id_i  in  CLR_PORTS*ID_W  entry to retire, per port.
- rd_mask_i  in  NUM_VREGS  source/dest vregs of the candidate instruction.
- hazard_o  out  1  rd_mask_i overlaps a pending write.
- pending_wr_o  out  NUM_VREGS  registered OR of all valid entry masks.
- busy_o  out  1  any entry valid.
- err_o  out  1  sticky protocol error.

Behaviour:
Reset (async, active-low):
- All entry valid bits and masks are 0.
- pending_wr_o, busy_o and err_o are 0; issue_ready_o is 1.

Per-entry state:
- valid bit plus a NUM_VREGS-bit mask.

Issue:
- Fires when issue_valid_i && issue_ready_o.
- At the next edge: valid[id] <= 1, mask[id] <= issue_mask_i.
- issue_ready_o = !valid[issue_id_i] || (any retire port targets issue_id_i this cycle).

Partial release:
- Per port p with clr_valid_i[p] set: mask[clr_id_i[p]] &= ~clr_mask_i[p].
- Multiple ports targeting the same entry combine by OR of their clear masks.
- Entry stays valid until retired.

Retire:
- Clears valid and mask of the targeted entry.
- Multiple ports may retire distinct IDs in the same cycle.

Simultaneous events, resolved in this order within one cycle:
- retire, then partial release, then issue.
- So issue into an entry being retired the same cycle installs the new mask.
- A partial release on an ID being issued the same cycle does not clear bits of the new mask.

Error conditions (err_o, sticky until reset or flush):
- Release or retire targeting an invalid entry: no state change, err_o set.
- Issue while !issue_ready_o: ignored, err_o set.

Flush:
- At the next edge clears all entries and err_o.
- Flush beats a same-cycle issue; the issue is dropped.

Timing:
- pending_wr_o and busy_o update the cycle after the causing event (registered).
- hazard_o is combinational: |(rd_mask_i & (pending_wr_o | (issue fire ? issue_mask_i : 0))).
- Same-cycle releases are not bypassed; hazard_o is conservative.

Width rules:
- IDs index entries directly; there is no wrap handling inside the block, and ID allocation belongs to the dispatcher.

Optional Feature:
Macro VPROC_PEND_PARTIAL_CLR_EN.
- Defined: per-vreg partial release as described above.
- Undefined: clr_valid_i, clr_id_i and clr_mask_i are ignored (ports remain, tied off internally); a mask is released only at retire.
- The undefined build has no partial-release logic and yields smaller area and stricter hazards.

Decomposition:
Shared package vproc_pkg:
- Typedef pend_id_t (logic [ID_W-1:0]).
- Typedef vreg_mask_t (logic [NUM_VREGS-1:0]).
- Constant PEND_ENTRIES = 2**ID_W.

Sub-module vproc_pending_wr_entry:
- One table slice: valid/mask registers plus a local hit decode for issue, release and retire.
- Instantiated PEND_ENTRIES times.
- Top level does the OR-reduction, ready/hazard logic and error collection.

Test Plan:
- Reset, then issue id=2 mask=32'h0000_00F0 → next cycle pending_wr_o=32'h0000_00F0, busy_o=1; rd_mask_i=32'h10 gives hazard_o=1.
- Id 2 pending with mask 32'hF0; port0 clr id=2 mask=32'h30 (macro defined) → pending_wr_o=32'hC0; retire id=2 → 0 and busy_o=0. With the macro undefined, the release leaves 32'hF0.
- Id 1 valid; same cycle retire id=1 on port1 and issue id=1 mask=32'h3 → issue_ready_o=1; next cycle pending_wr_o=32'h3, err_o=0.
- Empty table; issue id=0 mask=32'h1 with rd_mask_i=32'h1 in the same cycle → hazard_o=1 combinationally.
- Retire id=5 while invalid → err_o=1, pending_wr_o unchanged; flush_i → err_o=0, all entries cleared.
- Entries 0 and 3 valid (masks 32'hF, 32'hF00); assert async_rst_ni low mid-cycle → outputs clear immediately without waiting for a clock edge.
